sram_port_ctrl: RTL and testbench

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_port_ctrl_pkg.sv | 38 +++
 rtl/sram_port_ctrl_resp_fifo.sv | 70 +++++++
 rtl/sram_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_port_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_ctrl_pkg
// Description : Shared widths, response-buffer geometry and controller state
//               encoding for the SRAM port controller and its response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_port_ctrl_pkg;

    // Default geometry: 256 words of 24 bits, two 12-bit write segments.
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 24;
    localparam int MASK_W     = 2;

    // Response buffering: four entries, 2-bit wrapping pointers, occupancy 0..4.
    localparam int RESP_DEPTH = 4;
    localparam int RESP_PTR_W = 2;
    localparam int RESP_OCC_W = 3;

    // Credit limit expressed at the width of the credit sum.
    localparam logic [RESP_OCC_W:0] RESP_CREDITS = (RESP_OCC_W + 1)'(RESP_DEPTH);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Reads already committed to the response path: buffered entries plus the
    // read whose data is on its way back from the SRAM this cycle.
    function automatic logic [RESP_OCC_W:0] credits_used(
        input logic [RESP_OCC_W-1:0] occ,
        input logic                  inflight
    );
        return {1'b0, occ} + {{RESP_OCC_W{1'b0}}, inflight};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_port_ctrl_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_ctrl_resp_fifo
// Description : Four-entry response FIFO for read data returning from the
//               SRAM. Push and pop may occur in the same cycle. The producer
//               guarantees no push when full; the consumer pops only when
//               not empty.
// Ports       : clock, reset (async, active-high)
//               push/push_data - write one entry
//               pop/pop_data   - head entry, removed when pop is high
//               occ            - number of stored entries (0..4)
//               empty          - occ == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_ctrl_resp_fifo #(
    parameter int WIDTH = 24
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   push,
    input  logic [WIDTH-1:0]                       push_data,
    input  logic                                   pop,
    output logic [WIDTH-1:0]                       pop_data,
    output logic [sram_port_ctrl_pkg::RESP_OCC_W-1:0] occ,
    output logic                                   empty
);
    import sram_port_ctrl_pkg::*;

    localparam logic [RESP_PTR_W-1:0] c_ptr_step = RESP_PTR_W'(1);
    localparam logic [RESP_OCC_W-1:0] c_occ_step = RESP_OCC_W'(1);

    logic [WIDTH-1:0]      r_mem [RESP_DEPTH];
    logic [RESP_PTR_W-1:0] r_wr_ptr;
    logic [RESP_PTR_W-1:0] r_rd_ptr;
    logic [RESP_OCC_W-1:0] r_occ;

    // Storage carries no reset: an entry is only observed after being pushed.
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_step;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_step;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   r_occ <= r_occ + c_occ_step;
                2'b01:   r_occ <= r_occ - c_occ_step;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign occ      = r_occ;
    assign empty    = (r_occ == '0);

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_ctrl
// Description : Initiator for a single-port, 1-cycle read latency SRAM with
//               segment write masks. Accepted requests are driven straight
//               onto the SRAM pins in the same cycle; read data is captured
//               into a 4-entry response FIFO one cycle after issue and
//               returned in order. Requests are throttled by a credit rule
//               (buffered + in-flight reads < 4) so the FIFO never overflows.
// Config      : SRAM_PORT_CTRL_INIT_EN - when defined, the controller starts
//               in INIT and zeroes every word (one per cycle) before
//               accepting requests. When undefined it starts in RUN.
// Ports       : clock, reset (async, active-high)
//               req_valid/req_ready, req_write, req_addr, req_wmask,
//               req_wdata                       - request channel
//               resp_valid/resp_ready, resp_rdata - read response channel
//               sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
//               sram_rdata                      - SRAM macro interface
//               init_done                       - requests may be accepted
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_ctrl #(
    parameter int ADDR_W = sram_port_ctrl_pkg::ADDR_W,
    parameter int DATA_W = sram_port_ctrl_pkg::DATA_W,
    parameter int MASK_W = sram_port_ctrl_pkg::MASK_W
) (
    input  logic              clock,
    input  logic              reset,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    // response channel
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    // SRAM interface
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    // status
    output logic              init_done
);
    import sram_port_ctrl_pkg::*;

    state_t                w_state;
    logic                  w_init_wr;
    logic [ADDR_W-1:0]     w_init_addr;
    logic                  w_accept;
    logic                  w_rd_accept;
    logic                  r_inflight;
    logic [RESP_OCC_W-1:0] w_occ;
    logic                  w_empty;
    logic                  w_pop;

`ifdef SRAM_PORT_CTRL_INIT_EN
    localparam logic [ADDR_W-1:0] c_last_addr = '1;
    localparam logic [ADDR_W-1:0] c_cnt_step  = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] w_init_cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_init_wr      = 1'b0;
        case (r_state)
            INIT: begin
                // The state register already holds INIT while reset is high;
                // keep the SRAM idle until reset is released.
                w_init_wr      = !reset;
                w_init_cnt_nxt = r_init_cnt + c_cnt_step;
                if (r_init_cnt == c_last_addr) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign w_state     = r_state;
    assign w_init_addr = r_init_cnt;
`else
    assign w_state     = RUN;
    assign w_init_wr   = 1'b0;
    assign w_init_addr = '0;
`endif

    // Ready depends only on state and committed reads, never on the request.
    assign req_ready   = (w_state == RUN) && (credits_used(w_occ, r_inflight) < RESP_CREDITS);
    assign w_accept    = req_valid && req_ready;
    assign w_rd_accept = w_accept && !req_write;
    assign init_done   = (w_state == RUN);

    // SRAM pins: initialisation writes take priority (no request can be
    // accepted in INIT), otherwise the request payload passes straight through.
    always_comb begin
        sram_en = w_init_wr || w_accept;
        if (w_init_wr) begin
            sram_wmode = 1'b1;
            sram_addr  = w_init_addr;
            sram_wmask = '1;
            sram_wdata = '0;
        end else begin
            sram_wmode = req_write;
            sram_addr  = req_addr;
            sram_wmask = req_wmask;
            sram_wdata = req_wdata;
        end
    end

    // Marks the cycle in which the SRAM presents data for last cycle's read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_accept;
        end
    end

    assign resp_valid = !w_empty;
    assign w_pop      = resp_valid && resp_ready;

    sram_port_ctrl_resp_fifo #(
        .WIDTH     (DATA_W)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (sram_rdata),
        .pop       (w_pop),
        .pop_data  (resp_rdata),
        .occ       (w_occ),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_port_ctrl
// Description : Self-checking bench for sram_port_ctrl. Contains a behavioural
//               SRAM (1-cycle read latency, segment masks) and a transaction
//               level reference: a shadow memory updated on accepted writes
//               and a queue of expected read responses with their earliest
//               delivery cycle. Directed table vectors, hand-written corner
//               sequences and a randomized phase all run against it.
// Config      : SRAM_PORT_CTRL_INIT_EN - enables the initialisation checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port_ctrl;

    localparam int AW = 8;
    localparam int DW = 24;
    localparam int MW = 2;
    localparam int SEG = DW / MW;
    localparam int WORDS = 1 << AW;
    localparam int CREDITS = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [MW-1:0] req_wmask = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] sram_rdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          sram_en;
    logic          sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic          init_done;

    sram_port_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MASK_W     (MW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .init_done  (init_done)
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic [DW-1:0] sram_mem [WORDS];
    logic [DW-1:0] ref_mem  [WORDS];
    resp_t         exp_q [$];
    int            cyc = 0;
    int            post_rst = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    logic          s_req_ready, s_resp_valid, s_sram_en, s_init_done;
    logic [DW-1:0] s_resp_rdata;

    function automatic bit exp_done();
`ifdef SRAM_PORT_CTRL_INIT_EN
        return post_rst >= WORDS;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the model with the current
    // inputs, let the edge happen, then advance SRAM and model state.
    task automatic tick();
        bit            e_done, e_ready, acc, init_wr, e_rv;
        logic          p_en, p_we;
        logic [AW-1:0] p_addr;
        logic [MW-1:0] p_mask;
        logic [DW-1:0] p_wdata;
        #2;
        s_req_ready  = req_ready;
        s_resp_valid = resp_valid;
        s_resp_rdata = resp_rdata;
        s_sram_en    = sram_en;
        s_init_done  = init_done;
        e_done  = exp_done();
        init_wr = !e_done;
        e_ready = e_done && (exp_q.size() < CREDITS);
        acc     = req_valid && e_ready;
        check(init_done === e_done, "init_done", 64'(init_done), 64'(e_done));
        check(req_ready === e_ready, "req_ready", 64'(req_ready), 64'(e_ready));
        check(sram_en === (acc || init_wr), "sram_en", 64'(sram_en), 64'(acc || init_wr));
        if (init_wr)
            check({sram_wmode, sram_addr, sram_wmask, sram_wdata} === {1'b1, 8'(post_rst), 2'b11, 24'h0},
                  "init_write", 64'({sram_wmode, sram_addr, sram_wmask, sram_wdata}),
                  64'({1'b1, 8'(post_rst), 2'b11, 24'h0}));
        else if (acc)
            check({sram_wmode, sram_addr, sram_wmask, sram_wdata} === {req_write, req_addr, req_wmask, req_wdata},
                  "sram_pins", 64'({sram_wmode, sram_addr, sram_wmask, sram_wdata}),
                  64'({req_write, req_addr, req_wmask, req_wdata}));
        e_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check(resp_valid === e_rv, "resp_valid", 64'(resp_valid), 64'(e_rv));
        if (e_rv)
            check(resp_rdata === exp_q[0].data, "resp_rdata", 64'(resp_rdata), 64'(exp_q[0].data));
        p_en = sram_en; p_we = sram_wmode; p_addr = sram_addr; p_mask = sram_wmask; p_wdata = sram_wdata;
        @(posedge clock);
        // behavioural SRAM
        if (p_en === 1'b1) begin
            if (p_we === 1'b1) begin
                for (int i = 0; i < MW; i++)
                    if (p_mask[i]) sram_mem[p_addr][SEG*i +: SEG] = p_wdata[SEG*i +: SEG];
            end else begin
                sram_rdata <= sram_mem[p_addr];
            end
        end
        cyc++;
        post_rst++;
        if (e_rv && resp_ready) void'(exp_q.pop_front());
        if (acc) begin
            if (req_write) begin
                for (int i = 0; i < MW; i++)
                    if (req_wmask[i]) ref_mem[req_addr][SEG*i +: SEG] = req_wdata[SEG*i +: SEG];
            end else begin
                exp_q.push_back('{data: ref_mem[req_addr], due: cyc + 1});
            end
        end
        @(negedge clock);
    endtask

    task automatic apply_reset(input int hold, input bit check_now);
        reset = 1'b1;
        #1;
        if (check_now) check(resp_valid === 1'b0, "rst_resp_valid_now", 64'(resp_valid), 64'd0);
        exp_q.delete();
`ifdef SRAM_PORT_CTRL_INIT_EN
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
`endif
        repeat (hold) @(posedge clock);
        #1;
        check(resp_valid === 1'b0, "rst_resp_valid", 64'(resp_valid), 64'd0);
`ifdef SRAM_PORT_CTRL_INIT_EN
        check({sram_en, init_done} === 2'b00, "rst_en_done", 64'({sram_en, init_done}), 64'd0);
`else
        check(init_done === 1'b1, "rst_init_done", 64'(init_done), 64'd1);
`endif
        @(negedge clock);
        reset    = 1'b0;
        post_rst = 0;
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (!exp_done() && n < 300) begin
            tick();
            n++;
        end
        check(exp_done() && n < 300, "init_timeout", 64'(n), 64'(WORDS));
    endtask

    // ---------------------------------------------------------------- tests
    vec_t tbl [9];

    initial begin
        int acc, got, lat, first, last, nresp, nready, rise;
        logic [DW-1:0] rd;

        tbl[0] = '{1'b1, 8'h10, 2'b11, 24'hABCDEF, 24'h000000};
        tbl[1] = '{1'b0, 8'h10, 2'b00, 24'h000000, 24'hABCDEF};
        tbl[2] = '{1'b1, 8'h20, 2'b11, 24'h123456, 24'h000000};
        tbl[3] = '{1'b1, 8'h20, 2'b01, 24'hFFFFFF, 24'h000000};
        tbl[4] = '{1'b0, 8'h20, 2'b00, 24'h000000, 24'h123FFF};
        tbl[5] = '{1'b1, 8'h30, 2'b11, 24'h000000, 24'h000000};
        tbl[6] = '{1'b1, 8'h30, 2'b10, 24'hAAA555, 24'h000000};
        tbl[7] = '{1'b0, 8'h30, 2'b00, 24'h000000, 24'hAAA000};
        tbl[8] = '{1'b0, 8'hFF, 2'b00, 24'h000000, 24'h000000};

        for (int i = 0; i < WORDS; i++) begin
`ifdef SRAM_PORT_CTRL_INIT_EN
            sram_mem[i] = 24'h5A0000 | 24'(i + 1);
`else
            sram_mem[i] = '0;
`endif
            ref_mem[i] = '0;
        end

        apply_reset(3, 1'b0);

`ifdef SRAM_PORT_CTRL_INIT_EN
        rise = -1;
        nready = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (s_init_done === 1'b1) begin
                rise = i;
                break;
            end
            if (s_req_ready !== 1'b0) nready++;
        end
        check(rise == WORDS, "init_done_rise", 64'(rise), 64'(WORDS));
        check(nready == 0, "init_ready_low", 64'(nready), 64'd0);
`endif
        wait_init();

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            req_valid = 1'b1;
            req_write = tbl[i].wr;
            req_addr  = tbl[i].addr;
            req_wmask = tbl[i].mask;
            req_wdata = tbl[i].wdata;
            tick();
            check(s_req_ready === 1'b1, "tbl_accept", 64'(s_req_ready), 64'd1);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            if (!tbl[i].wr) begin
                rd = 'x;
                for (lat = 1; lat <= 8; lat++) begin
                    tick();
                    if (s_resp_valid === 1'b1) begin
                        rd = s_resp_rdata;
                        break;
                    end
                end
                check(lat == 2, "tbl_latency", 64'(lat), 64'd2);
                check(rd === tbl[i].exp_rdata, "tbl_rdata", 64'(rd), 64'(tbl[i].exp_rdata));
            end else begin
                tick();
            end
        end

        // Known data at 0x40..0x45 for the ordering checks.
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_wmask = 2'b11;
            req_addr  = 8'h40 + 8'(i);
            req_wdata = 24'hC0FF00 + 24'(i);
            tick();
        end
        req_valid = 1'b0;
        tick();

        // Backpressure: only four reads fit, then the port stalls.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_addr = 8'h40 + 8'(acc);
            tick();
            if (s_req_ready === 1'b1) acc++;
        end
        check(acc == 4, "bp_accepted", 64'(acc), 64'd4);
        check({s_req_ready, s_sram_en} === 2'b00, "bp_stalled", 64'({s_req_ready, s_sram_en}), 64'd0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got < 4; i++) begin
            tick();
            if (s_resp_valid === 1'b1) begin
                check(s_resp_rdata === 24'hC0FF00 + 24'(got), "bp_order",
                      64'(s_resp_rdata), 64'(24'hC0FF00 + 24'(got)));
                got++;
            end
        end
        check(got == 4, "bp_count", 64'(got), 64'd4);
        tick();
        check(s_req_ready === 1'b1, "bp_ready_again", 64'(s_req_ready), 64'd1);

        // Streaming: one read per cycle with the consumer always ready.
        resp_ready = 1'b1;
        nresp = 0; nready = 0; first = -1; last = -1;
        for (int i = 0; i < 22; i++) begin
            req_valid = (i < 16);
            req_write = 1'b0;
            req_addr  = 8'h40 + 8'(i % 6);
            tick();
            if (i < 16 && s_req_ready === 1'b1) nready++;
            if (s_resp_valid === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                nresp++;
            end
        end
        check(nready == 16, "stream_ready", 64'(nready), 64'd16);
        check(nresp == 16, "stream_resps", 64'(nresp), 64'd16);
        check(last - first == 15, "stream_back_to_back", 64'(last - first), 64'd15);

        // Reset with two responses buffered and one read in flight.
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 8'h41 + 8'(i);
            tick();
        end
        req_valid = 1'b0;
        #1;
        check(resp_valid === 1'b1, "pre_rst_resp_valid", 64'(resp_valid), 64'd1);
        apply_reset(2, 1'b1);
        wait_init();
        resp_ready = 1'b1;
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_resp_valid !== 1'b0) nresp++;
        end
        check(nresp == 0, "no_stale_resp", 64'(nresp), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 9) < 7);
            req_write  = ($urandom_range(0, 9) < 4);
            req_addr   = 8'($urandom_range(0, 15));
            req_wmask  = 2'($urandom_range(0, 3));
            req_wdata  = 24'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        check(s_resp_valid === 1'b0, "drain_idle", 64'(s_resp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
